// File: rtl/mem_stage.sv
// Memory-access stage: multi-cycle word load/store against an internal data
// memory, with upstream stall, writeback latch and branch redirect.
module mem_stage #(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [5:0]  rd,
  input  logic        branch,
  input  logic [31:0] newPC,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [5:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  logic [31:0]   mem [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] idx;
  logic          memop;
  logic          err;
  logic          acc;
  logic          done;

  assign idx = alu_result[AW+1:2];

  // cnt is the access FSM: zero is IDLE, anything else is WAIT
  always_comb begin
    memop = mem_read | mem_write;
    err   = memop & ((alu_result[1:0] != 2'b00)
                   | (|alu_result[31:AW+2])
                   | (mem_read & mem_write));
    acc   = in_valid & memop & ~err;
    stall = acc & (cnt_q != LAST);
    done  = acc & (cnt_q == LAST);
    cnt_d = '0;
    if (stall)
      cnt_d = cnt_q + CW'(1);
  end

  assign pc_src        = in_valid & branch;
  assign branch_target = newPC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      addr_err     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (stall) begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
        addr_err     <= 1'b0;
      end else begin
        wb_valid     <= in_valid;
        wb_reg_write <= in_valid & reg_write & ~(memop & err);
        wb_rd        <= rd;
        wb_data      <= (done & mem_read) ? mem[idx] : alu_result;
        addr_err     <= in_valid & memop & err;
      end
    end
  end

  // storage is deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (done & mem_write)
      mem[idx] <= store_data;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances (MEM_LAT 1/2/3) share
// stimulus; each section checks only the instance it targets.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [5:0]  rd;
  logic        branch;
  logic [31:0] newPC;

  logic        stall         [1:3];
  logic        pc_src        [1:3];
  logic [31:0] branch_target [1:3];
  logic        wb_valid      [1:3];
  logic        wb_reg_write  [1:3];
  logic [5:0]  wb_rd         [1:3];
  logic [31:0] wb_data       [1:3];
  logic        addr_err      [1:3];

  int n_tot = 0;
  int n_bad = 0;

  mem_stage #(.DEPTH(256), .MEM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .branch(branch),
    .newPC(newPC), .stall(stall[1]), .pc_src(pc_src[1]),
    .branch_target(branch_target[1]), .wb_valid(wb_valid[1]),
    .wb_reg_write(wb_reg_write[1]), .wb_rd(wb_rd[1]),
    .wb_data(wb_data[1]), .addr_err(addr_err[1])
  );

  mem_stage #(.DEPTH(256), .MEM_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .branch(branch),
    .newPC(newPC), .stall(stall[2]), .pc_src(pc_src[2]),
    .branch_target(branch_target[2]), .wb_valid(wb_valid[2]),
    .wb_reg_write(wb_reg_write[2]), .wb_rd(wb_rd[2]),
    .wb_data(wb_data[2]), .addr_err(addr_err[2])
  );

  mem_stage #(.DEPTH(256), .MEM_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .branch(branch),
    .newPC(newPC), .stall(stall[3]), .pc_src(pc_src[3]),
    .branch_target(branch_target[3]), .wb_valid(wb_valid[3]),
    .wb_reg_write(wb_reg_write[3]), .wb_rd(wb_rd[3]),
    .wb_data(wb_data[3]), .addr_err(addr_err[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic v, input logic r, input logic w,
                     input logic rw, input logic [31:0] a,
                     input logic [31:0] sd, input logic [5:0] d,
                     input logic br, input logic [31:0] npc);
    in_valid   = v;
    mem_read   = r;
    mem_write  = w;
    reg_write  = rw;
    alu_result = a;
    store_data = sd;
    rd         = d;
    branch     = br;
    newPC      = npc;
  endtask

  task automatic idle();
    put(0, 0, 0, 0, 32'h0, 32'h0, 6'd0, 0, 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic        G_W [6] = '{1, 0, 1, 0, 1, 0};
  localparam logic [31:0] G_A [6] = '{32'h0, 32'h0, 32'h4,
                                      32'h4, 32'h0, 32'h0};
  localparam logic [31:0] G_D [6] = '{32'hA0A0A0A0, 32'hA0A0A0A0,
                                      32'hB4B4B4B4, 32'hB4B4B4B4,
                                      32'hC0C0C0C0, 32'hC0C0C0C0};

  localparam logic        F_R [3] = '{1, 1, 1};
  localparam logic        F_W [3] = '{0, 0, 1};
  localparam logic [31:0] F_A [3] = '{32'h41, 32'h400, 32'h40};

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid[2]), 32'd0);
    chk("rst_wb_regw", 32'(wb_reg_write[2]), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd[2]), 32'd0);
    chk("rst_wb_data", wb_data[2], 32'h0);
    chk("rst_addr_err", 32'(addr_err[2]), 32'd0);
    chk("rst_stall", 32'(stall[2]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MEM_LAT=2 store then load
    put(1, 0, 1, 0, 32'h40, 32'hDEADBEEF, 6'd0, 0, 32'h0);
    #1 chk("l2_st_stall_t", 32'(stall[2]), 32'd1);
    @(negedge clk);
    chk("l2_st_stall_t1", 32'(stall[2]), 32'd0);
    chk("l2_st_bubble", 32'(wb_valid[2]), 32'd0);
    @(negedge clk);
    chk("l2_st_wb_valid", 32'(wb_valid[2]), 32'd1);
    chk("l2_st_wb_regw", 32'(wb_reg_write[2]), 32'd0);
    put(1, 1, 0, 1, 32'h40, 32'h0, 6'd5, 0, 32'h0);
    #1 chk("l2_ld_stall", 32'(stall[2]), 32'd1);
    repeat (2) @(negedge clk);
    chk("l2_ld_data", wb_data[2], 32'hDEADBEEF);
    chk("l2_ld_rd", 32'(wb_rd[2]), 32'd5);
    chk("l2_ld_regw", 32'(wb_reg_write[2]), 32'd1);
    chk("l2_ld_valid", 32'(wb_valid[2]), 32'd1);
    idle();

    // MEM_LAT=3: ALU pass-through, store, then a stalled load
    pulse_reset();
    put(1, 0, 0, 1, 32'h1234, 32'h0, 6'd3, 0, 32'h0);
    #1 chk("l3_alu_stall", 32'(stall[3]), 32'd0);
    @(negedge clk);
    chk("l3_alu_data", wb_data[3], 32'h1234);
    chk("l3_alu_rd", 32'(wb_rd[3]), 32'd3);
    chk("l3_alu_valid", 32'(wb_valid[3]), 32'd1);
    put(1, 0, 1, 0, 32'h10, 32'h11111111, 6'd0, 0, 32'h0);
    repeat (3) @(negedge clk);
    put(1, 1, 0, 1, 32'h10, 32'h0, 6'd6, 0, 32'h0);
    #1 chk("l3_ld_stall0", 32'(stall[3]), 32'd1);
    @(negedge clk);
    chk("l3_ld_stall1", 32'(stall[3]), 32'd1);
    chk("l3_ld_bubble1", 32'(wb_valid[3]), 32'd0);
    @(negedge clk);
    chk("l3_ld_stall2", 32'(stall[3]), 32'd0);
    chk("l3_ld_bubble2", 32'(wb_valid[3]), 32'd0);
    @(negedge clk);
    chk("l3_ld_valid", 32'(wb_valid[3]), 32'd1);
    chk("l3_ld_data", wb_data[3], 32'h11111111);
    idle();

    // reset in WAIT drops the pending store
    @(negedge clk);
    put(1, 0, 1, 0, 32'h10, 32'h22222222, 6'd0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_wait_cnt", 32'(u3.cnt_q), 32'd0);
    chk("rst_wait_valid", 32'(wb_valid[3]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    put(1, 1, 0, 1, 32'h10, 32'h0, 6'd7, 0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_wait_ld", wb_data[3], 32'h11111111);
    idle();
    @(negedge clk);

    // faults on MEM_LAT=2
    for (int i = 0; i < 3; i++) begin
      put(1, F_R[i], F_W[i], 1, F_A[i], 32'h0BADF00D, 6'd4, 0, 32'h0);
      #1 chk($sformatf("flt%0d_stall", i), 32'(stall[2]), 32'd0);
      @(negedge clk);
      chk($sformatf("flt%0d_err", i), 32'(addr_err[2]), 32'd1);
      chk($sformatf("flt%0d_regw", i), 32'(wb_reg_write[2]), 32'd0);
      chk($sformatf("flt%0d_valid", i), 32'(wb_valid[2]), 32'd1);
    end
    put(1, 1, 0, 1, 32'h40, 32'h0, 6'd8, 0, 32'h0);
    repeat (2) @(negedge clk);
    chk("flt_mem_kept", wb_data[2], 32'hDEADBEEF);
    chk("flt_clr_err", 32'(addr_err[2]), 32'd0);

    // branch held across a load stall
    put(1, 1, 0, 1, 32'h40, 32'h0, 6'd9, 1, 32'h200);
    #1 chk("br_pc_src0", 32'(pc_src[2]), 32'd1);
    chk("br_tgt0", branch_target[2], 32'h200);
    chk("br_stall0", 32'(stall[2]), 32'd1);
    @(negedge clk);
    chk("br_pc_src1", 32'(pc_src[2]), 32'd1);
    chk("br_tgt1", branch_target[2], 32'h200);
    @(negedge clk);
    put(0, 0, 0, 0, 32'h0, 32'h0, 6'd0, 1, 32'h200);
    #1 chk("br_invalid", 32'(pc_src[2]), 32'd0);
    @(negedge clk);

    // MEM_LAT=1 back-to-back store/load
    for (int i = 0; i < 6; i++) begin
      put(1, ~G_W[i], G_W[i], ~G_W[i], G_A[i], G_D[i], 6'd2, 0, 32'h0);
      #1 chk($sformatf("l1_stall%0d", i), 32'(stall[1]), 32'd0);
      @(negedge clk);
      if (!G_W[i])
        chk($sformatf("l1_ld%0d", i), wb_data[1], G_D[i]);
    end
    idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
